fill_report_tx: RTL and testbench

Transmit end of the matcher's fill stream. Accepts fill records (maker side, price, quantity) on a valid/ready port, buffers them in a small FIFO and tags each with a 32-bit sequence number. It then serializes each record into a fixed 16-byte big-endian execution-report message on a byte-wide valid/ready stream for the downstream report/MAC path.

---
 rtl/fill_report_tx.sv | 127 ++++++++++++
 tb/tb_fill_report_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fill_report_tx.sv
// Fill report transmitter: queues fill records and serializes each one
// into a 16-byte big-endian execution report on a byte stream.
module fill_report_tx #(
  parameter int PRICE_W = 48,
  parameter int QTY_W   = 32,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               tfill_v,
  output logic               tfill_r,
  input  logic               tfill_side,
  input  logic [PRICE_W-1:0] tfill_price,
  input  logic [QTY_W-1:0]   tfill_qty,
  output logic               out_v,
  input  logic               out_r,
  output logic [7:0]         out_data,
  output logic               out_sof,
  output logic               out_eof,
  output logic               busy,
  output logic [31:0]        next_seq
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic               side;
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   qty;
  } rec_t;

  typedef enum logic {IDLE, SEND} state_t;

  rec_t           mem [DEPTH];
  rec_t           head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           full;
  logic           empty;
  logic           push;
  logic           load;
  logic           hs;
  logic           last_hs;

  state_t         state;
  state_t         state_n;
  logic [127:0]   msg;
  logic [3:0]     idx;
  logic [31:0]    seq_q;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign tfill_r = !full;
  assign push    = tfill_v && !full;
  assign head    = mem[rd_ptr];
  assign hs      = (state == SEND) && out_r;
  assign last_hs = hs && (idx == 4'd15);
  assign load    = !empty && ((state == IDLE) || last_hs);
  assign busy    = !empty || (state == SEND);
  assign next_seq = seq_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{tfill_side, tfill_price, tfill_qty};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (!empty) state_n = SEND;
      SEND:    if (last_hs && empty) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Message register shifts left per accepted byte; the top byte is on the wire.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      msg   <= '0;
      idx   <= '0;
      seq_q <= 32'd1;
    end else if (load) begin
      msg   <= {8'h46, head.side ? 8'h53 : 8'h42, seq_q,
                48'(head.price), 32'(head.qty)};
      idx   <= '0;
      seq_q <= seq_q + 32'd1;
    end else if (hs) begin
      msg   <= {msg[119:0], 8'h00};
      idx   <= idx + 4'd1;
    end
  end

  always_comb begin
    out_v    = 1'b0;
    out_data = 8'h00;
    out_sof  = 1'b0;
    out_eof  = 1'b0;
    if (state == SEND) begin
      out_v    = 1'b1;
      out_data = msg[127:120];
      out_sof  = (idx == 4'd0);
      out_eof  = (idx == 4'd15);
    end
  end

endmodule

// File: tb/tb_fill_report_tx.sv
// Directed bench for fill_report_tx: message bytes, framing, FIFO full,
// stalls, sequence wrap and mid-message reset.
module tb_fill_report_tx;

  logic        clk = 1'b0;
  logic        rstn;
  logic        tfill_v;
  logic        tfill_r;
  logic        tfill_side;
  logic [47:0] tfill_price;
  logic [31:0] tfill_qty;
  logic        out_v;
  logic        out_r;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic        busy;
  logic [31:0] next_seq;

  int errs = 0;
  int checks = 0;

  fill_report_tx #(.PRICE_W(48), .QTY_W(32), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .tfill_v(tfill_v), .tfill_r(tfill_r),
    .tfill_side(tfill_side), .tfill_price(tfill_price),
    .tfill_qty(tfill_qty),
    .out_v(out_v), .out_r(out_r), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof),
    .busy(busy), .next_seq(next_seq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input bit s, input logic [31:0] seq,
                                      input logic [47:0] p,
                                      input logic [31:0] q);
    return {8'h46, s ? 8'h53 : 8'h42, seq, p, q};
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input bit s, input logic [47:0] p,
                      input logic [31:0] q);
    tfill_v     = 1'b1;
    tfill_side  = s;
    tfill_price = p;
    tfill_qty   = q;
    @(negedge clk);
    tfill_v     = 1'b0;
  endtask

  task automatic recv_msg(input logic [127:0] m, input bit stall,
                          input bit nogap, input int nb);
    int k = 0;
    int cyc = 0;
    logic [7:0] eb;
    while (k < nb) begin
      if (cyc > 400) begin
        chk("recv_timeout", k, nb);
        break;
      end
      if (out_v) begin
        eb = m[127-8*k -: 8];
        chk($sformatf("byte%0d", k), out_data, eb);
        chk($sformatf("sof%0d", k), out_sof, k == 0);
        chk($sformatf("eof%0d", k), out_eof, k == 15);
        out_r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_r) k++;
      end else begin
        if (nogap) chk("gap", out_v, 1'b1);
        out_r = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    out_r = 1'b1;
  endtask

  logic [127:0] m3;

  initial begin
    rstn        = 1'b0;
    tfill_v     = 1'b0;
    tfill_side  = 1'b0;
    tfill_price = '0;
    tfill_qty   = '0;
    out_r       = 1'b1;

    // reset values
    do_reset();
    chk("rst_out_v", out_v, 1'b0);
    chk("rst_sof", out_sof, 1'b0);
    chk("rst_eof", out_eof, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tfill_r", tfill_r, 1'b1);
    chk("rst_next_seq", next_seq, 32'd1);

    // single fill, byte 0 two cycles after acceptance
    push(1'b1, 48'h000000012345, 32'h64);
    chk("lat_out_v_e0", out_v, 1'b0);
    chk("lat_busy", busy, 1'b1);
    @(negedge clk);
    chk("lat_out_v_e1", out_v, 1'b1);
    recv_msg(128'h4653_00000001_000000012345_00000064, 1'b0, 1'b1, 16);
    chk("single_idle", out_v, 1'b0);
    chk("single_busy", busy, 1'b0);
    chk("single_next_seq", next_seq, 32'd2);

    // five fills back-to-back with output held off, then gap-free drain
    do_reset();
    out_r = 1'b0;
    for (int i = 1; i <= 5; i++)
      push(i[0], 48'(i * 1000), 32'(i * 7));
    chk("full_tfill_r", tfill_r, 1'b0);
    push(1'b1, 48'hDEAD, 32'hBEEF);
    chk("full_held", tfill_r, 1'b0);
    for (int i = 1; i <= 5; i++)
      recv_msg(mk(i[0], 32'(i), 48'(i * 1000), 32'(i * 7)), 1'b0, 1'b1, 16);
    chk("five_idle", out_v, 1'b0);
    chk("five_busy", busy, 1'b0);
    chk("five_next_seq", next_seq, 32'd6);

    // random backpressure
    push(1'b0, 48'hA1B2C3D4E5F6, 32'h89ABCDEF);
    recv_msg(mk(1'b0, 32'd6, 48'hA1B2C3D4E5F6, 32'h89ABCDEF), 1'b1, 1'b0, 16);
    chk("stall_next_seq", next_seq, 32'd7);

    // sequence wrap
    force dut.seq_q = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.seq_q;
    chk("wrap_forced", next_seq, 32'hFFFFFFFF);
    push(1'b1, 48'h111, 32'h222);
    push(1'b0, 48'h333, 32'h444);
    recv_msg(mk(1'b1, 32'hFFFFFFFF, 48'h111, 32'h222), 1'b0, 1'b0, 16);
    recv_msg(mk(1'b0, 32'h00000000, 48'h333, 32'h444), 1'b0, 1'b1, 16);
    chk("wrap_next_seq", next_seq, 32'd1);

    // reset at byte 7 of message seq 3 with two records queued
    do_reset();
    out_r = 1'b0;
    for (int i = 1; i <= 5; i++)
      push(1'b1, 48'(i + 16), 32'(i + 32));
    recv_msg(mk(1'b1, 32'd1, 48'd17, 32'd33), 1'b0, 1'b1, 16);
    recv_msg(mk(1'b1, 32'd2, 48'd18, 32'd34), 1'b0, 1'b1, 16);
    m3 = mk(1'b1, 32'd3, 48'd19, 32'd35);
    recv_msg(m3, 1'b0, 1'b1, 7);
    chk("pre_rst_byte7", out_data, m3[71:64]);
    rstn = 1'b0;
    #1;
    chk("mid_rst_out_v", out_v, 1'b0);
    chk("mid_rst_eof", out_eof, 1'b0);
    chk("mid_rst_data", out_data, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_tfill_r", tfill_r, 1'b1);
    chk("mid_rst_next_seq", next_seq, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // zero fill after reset carries seq 1; flushed records never appear
    push(1'b0, 48'h0, 32'h0);
    chk("zero_lat", out_v, 1'b0);
    recv_msg(128'h4642_00000001_000000000000_00000000, 1'b0, 1'b0, 16);
    for (int i = 0; i < 4; i++) begin
      chk("flushed_idle", out_v, 1'b0);
      @(negedge clk);
    end
    chk("final_busy", busy, 1'b0);
    chk("final_next_seq", next_seq, 32'd2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
